mips_state_sequencer: RTL and testbench

Multicycle state sequencer for the MIPS CPU core. It generates the 3-bit `state` that drives the per-state control decoder and sequences each instruction through only the phases it needs. It stretches memory phases while the Avalon bus asserts `waitrequest` and holds EXECUTE for multicycle divide. It also detects the halt condition (jump to address 0) and drives `active`. It sits between the instruction register, the PC mux and the control decoder.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/phase_decoder.sv | 20 ++
 rtl/mips_state_sequencer.sv | 75 +++++++
 tb/tb_mips_state_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared phase encoding, opcode/func constants and ALU operation type for the MIPS core
package mips_pkg;
    typedef enum logic [2:0] {
        FETCH         = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALTED        = 3'b101
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS
    } ALUOperation_t;
endpackage

// File: rtl/phase_decoder.sv
// phase_decoder: maps final_code to the optional phases an instruction needs
module phase_decoder
    import mips_pkg::*;
(
    input  logic       r_type,
    input  logic [5:0] final_code,
    output logic       needs_mem,
    output logic       needs_wb,
    output logic       is_div
);
    // r_type disambiguates func codes that alias opcodes (SUBU/LW, SLTU/SW)
    always_comb begin
        needs_mem = !r_type && (final_code == OP_LW || final_code == OP_SW);
        is_div    = r_type && (final_code == FN_DIV || final_code == FN_DIVU);
        needs_wb  = r_type
            ? final_code inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JALR,
                                 FN_MFHI, FN_MFLO, [FN_ADD:FN_NOR], FN_SLT, FN_SLTU}
            : final_code inside {OP_JAL, [OP_ADDI:OP_LUI], OP_LW};
    end
endmodule

// File: rtl/mips_state_sequencer.sv
// mips_state_sequencer: multicycle phase sequencer with bus-wait and divide holds and halt detection
module mips_state_sequencer
    import mips_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        waitrequest,
    input  logic [31:0] pc_next,
    output state_t      state,
    output logic        active,
    output logic        stall,
    output logic        instr_done,
    output logic [31:0] instr_count
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    state_t        next_state;
    state_t        after_done;
    logic [CW-1:0] div_cnt;
    logic          needs_mem, needs_wb, is_div, last_phase, div_last;
    logic          r_type;
    logic [5:0]    final_code;

    assign r_type     = opcode == OP_RTYPE;
    assign final_code = r_type ? func_code : opcode;
    assign after_done = pc_next == '0 ? HALTED : FETCH;

    phase_decoder u_phase_decoder (
        .r_type    (r_type),
        .final_code(final_code),
        .needs_mem (needs_mem),
        .needs_wb  (needs_wb),
        .is_div    (is_div)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            active      <= 1'b1;
            instr_count <= '0;
            div_cnt     <= '0;
        end else begin
            state       <= next_state;
            active      <= next_state != HALTED;
            instr_count <= instr_count + 32'(instr_done);
            div_cnt     <= (state == EXECUTE && stall) ? div_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        case (state)
            FETCH:         next_state = stall ? FETCH : DECODE;
            DECODE:        next_state = EXECUTE;
            EXECUTE:       next_state = stall ? EXECUTE : instr_done ? after_done
                                      : needs_mem ? MEMORY_ACCESS : WRITE_BACK;
            MEMORY_ACCESS: next_state = stall ? MEMORY_ACCESS : instr_done ? after_done : WRITE_BACK;
            WRITE_BACK:    next_state = after_done;
            HALTED:        next_state = HALTED;
            default:       next_state = FETCH;
        endcase
    end

    always_comb begin
        div_last   = div_cnt == CW'(DIV_CYCLES - 1);
        stall      = (state == FETCH || state == MEMORY_ACCESS) ? waitrequest
                   : (state == EXECUTE && is_div && !div_last);
        last_phase = state == WRITE_BACK || (state == MEMORY_ACCESS && !needs_wb)
                   || (state == EXECUTE && !needs_mem && !needs_wb);
        instr_done = last_phase && !stall;
    end
endmodule

// File: tb/tb_mips_state_sequencer.sv
// tb_mips_state_sequencer: directed and randomized instruction streams against a phase-list model
module tb_mips_state_sequencer;
    localparam int DIV_CYCLES = 4;

    typedef struct {
        logic [2:0] st;
        logic       wr;
        logic       stl;
        logic       dn;
    } step_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  func_code = '0;
    logic        waitrequest = 1'b1;
    logic [31:0] pc_next = 32'h4;
    logic [2:0]  state;
    logic        active, stall, instr_done;
    logic [31:0] instr_count;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_count = '0;
    step_t       seq[$];

    mips_state_sequencer #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .func_code  (func_code),
        .waitrequest(waitrequest),
        .pc_next    (pc_next),
        .state      (state),
        .active     (active),
        .stall      (stall),
        .instr_done (instr_done),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // 0: F D E, 1: F D E W, 2: F D E M W, 3: F D E M, 4: divide
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h1a || fn == 6'h1b) return 4;
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                           [6'h20:6'h27], 6'h2a, 6'h2b}) return 1;
            return 0;
        end
        if (op == 6'h23) return 2;
        if (op == 6'h2b) return 3;
        if (op == 6'h03 || (op >= 6'h08 && op <= 6'h0f)) return 1;
        return 0;
    endfunction

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_active", 32'(active), 32'd1);
        check("rst_count", instr_count, 32'd0);
        waitrequest = 1'b1;
        reset = 1'b0;
        exp_count = '0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm,
                             input bit halt, input int abort_at);
        int k = kind(op, fn);
        int ne = (k == 4) ? DIV_CYCLES : 1;
        seq.delete();
        for (int i = 0; i < wf; i++) seq.push_back('{3'd0, 1'b1, 1'b1, 1'b0});
        seq.push_back('{3'd0, 1'b0, 1'b0, 1'b0});
        seq.push_back('{3'd1, 1'($urandom), 1'b0, 1'b0});
        for (int i = 0; i < ne; i++) seq.push_back('{3'd2, 1'($urandom), i < ne - 1, 1'b0});
        if (k == 2 || k == 3) begin
            for (int i = 0; i < wm; i++) seq.push_back('{3'd3, 1'b1, 1'b1, 1'b0});
            seq.push_back('{3'd3, 1'b0, 1'b0, 1'b0});
        end
        if (k == 1 || k == 2) seq.push_back('{3'd4, 1'($urandom), 1'b0, 1'b0});
        seq[seq.size() - 1].dn = 1'b1;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            waitrequest = seq[i].wr;
            opcode      = seq[i].st == 3'd0 ? 6'($urandom) : op;
            func_code   = seq[i].st == 3'd0 ? 6'($urandom) : fn;
            pc_next     = seq[i].dn ? (halt ? 32'h0 : 32'h400 + (32'($urandom_range(0, 255)) << 2))
                                    : 32'($urandom_range(0, 3)) << 2;
            #1;
            check("state", 32'(state), 32'(seq[i].st));
            check("stall", 32'(stall), 32'(seq[i].stl));
            check("done", 32'(instr_done), 32'(seq[i].dn));
            if (i == abort_at) begin
                pulse_reset();
                return;
            end
        end
        exp_count++;
        @(negedge clk);
        check("end_state", 32'(state), halt ? 32'd5 : 32'd0);
        check("end_active", 32'(active), halt ? 32'd0 : 32'd1);
        check("count", instr_count, exp_count);
        waitrequest = 1'b1;
    endtask

    task automatic halted_then_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            waitrequest = 1'($urandom);
            opcode      = 6'($urandom);
            func_code   = 6'($urandom);
            pc_next     = 32'($urandom_range(0, 3)) << 2;
            #1;
            check("halt_state", 32'(state), 32'd5);
            check("halt_active", 32'(active), 32'd0);
            check("halt_stall", 32'(stall), 32'd0);
            check("halt_done", 32'(instr_done), 32'd0);
            check("halt_count", instr_count, exp_count);
        end
        @(negedge clk);
        pulse_reset();
    endtask

    initial begin
        logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h08, 6'h09, 6'h0f, 6'h23, 6'h23, 6'h2b, 6'h20, 6'h01};
        #12;
        check("init_state", 32'(state), 32'd0);
        check("init_active", 32'(active), 32'd1);
        check("init_count", instr_count, 32'd0);
        check("init_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        run_instr(6'h00, 6'h21, 0, 0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, -1);
        run_instr(6'h00, 6'h1a, 0, 0, 1'b0, -1);
        run_instr(6'h00, 6'h08, 0, 0, 1'b1, -1);
        halted_then_reset();
        run_instr(6'h00, 6'h2b, 0, 0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 0, 3, 1'b0, 4);
        run_instr(6'h23, 6'h00, 0, 0, 1'b0, -1);
        run_instr(6'h2b, 6'h00, 2, 0, 1'b0, -1);
        run_instr(6'h00, 6'h23, 1, 0, 1'b0, -1);
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op = ops[$urandom_range(0, 15)];
            logic [5:0] fn = 6'($urandom);
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, -1);
        end
        run_instr(6'h00, 6'h1b, 1, 0, 1'b1, -1);
        halted_then_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
